// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: bridges the datapath MIO_EN/R handshake to a
// wait-stated RAM port and to the memory-mapped keyboard/display registers
// (KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06).
module lc3_mem_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_in,
    output logic [15:0] rdata,
    output logic        R,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        INT
);

    // Counter preload: BUSY lasts WAIT_STATES cycles, leaving at count 0.
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);
    localparam logic [15:0] DEV_BASE  = 16'hFE00;

    localparam logic [1:0] IDX_KBSR = 2'd0;
    localparam logic [1:0] IDX_KBDR = 2'd1;
    localparam logic [1:0] IDX_DSR  = 2'd2;
    localparam logic [1:0] IDX_DDR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic        rw_reg;        // latched R_W of the access in flight
    logic        dev_reg;       // access in flight targets a device register
    logic [1:0]  dev_idx_reg;   // which device register
    logic [15:0] rdata_reg;     // read data held between DONE cycles

    logic        kbsr15_reg;    // keyboard ready
    logic        kbsr14_reg;    // keyboard interrupt enable
    logic [7:0]  kbdr_reg;

    logic [3:0]  dev_hit;
    logic        dev_sel;
    logic [1:0]  dev_idx;
    logic [15:0] dev_rdata;
    logic        dev_done;
    logic        kbdr_rd;
    logic        kbsr_wr;
    logic        ddr_wr;
    logic        kb_accept;

    // One comparator per device register address (xFE00 + 2*gi).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dev_decode
            assign dev_hit[gi] = (MAR == (DEV_BASE + 16'(2 * gi)));
        end
    endgenerate

    assign dev_sel = |dev_hit;

    // Encode the device hit vector into a register index.
    always_comb begin
        dev_idx = IDX_KBSR;
        if (dev_hit[1]) begin
            dev_idx = IDX_KBDR;
        end else if (dev_hit[2]) begin
            dev_idx = IDX_DSR;
        end else if (dev_hit[3]) begin
            dev_idx = IDX_DDR;
        end
    end

    // Zero-extended device read value from the current register state.
    always_comb begin
        dev_rdata = 16'h0000;
        case (dev_idx_reg)
            IDX_KBSR: dev_rdata = {kbsr15_reg, kbsr14_reg, 14'b0};
            IDX_KBDR: dev_rdata = {8'h00, kbdr_reg};
            IDX_DSR:  dev_rdata = {~dsp_valid, 15'b0};
            default:  dev_rdata = 16'h0000;
        endcase
    end

    // Device side effects all happen in the DONE cycle of a device access.
    assign dev_done = (state_reg == DONE) && dev_reg;
    assign kbdr_rd  = dev_done && !rw_reg && (dev_idx_reg == IDX_KBDR);
    assign kbsr_wr  = dev_done &&  rw_reg && (dev_idx_reg == IDX_KBSR);
    assign ddr_wr   = dev_done &&  rw_reg && (dev_idx_reg == IDX_DDR);

    // A KBDR read frees the buffer in the same cycle, so a byte arriving
    // alongside the read is accepted rather than dropped.
    assign kb_accept = kb_valid && (!kbsr15_reg || kbdr_rd);

    // Device reads present the live register value during DONE, so a
    // keyboard byte landing in that cycle does not disturb the returned
    // data; the value is then held in rdata_reg.
    assign rdata = (dev_done && !rw_reg) ? dev_rdata : rdata_reg;

    assign INT = kbsr15_reg && kbsr14_reg;

    // Access sequencer with registered handshake and RAM port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            count_reg   <= 4'd0;
            rw_reg      <= 1'b0;
            dev_reg     <= 1'b0;
            dev_idx_reg <= IDX_KBSR;
            rdata_reg   <= 16'h0000;
            R           <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    R      <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (MIO_EN) begin
                        mem_addr    <= MAR;
                        mem_wdata   <= MDR_in;
                        rw_reg      <= R_W;
                        dev_reg     <= dev_sel;
                        dev_idx_reg <= dev_idx;
                        if (dev_sel) begin
                            state_reg <= DONE;
                            R         <= 1'b1;
                        end else begin
                            state_reg <= BUSY;
                            count_reg <= WAIT_LOAD;
                            mem_en    <= 1'b1;
                            mem_we    <= R_W;
                        end
                    end
                end
                BUSY: begin
                    if (count_reg == 4'd0) begin
                        if (!rw_reg) begin
                            rdata_reg <= mem_rdata;
                        end
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        R         <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                DONE: begin
                    R         <= 1'b0;
                    state_reg <= IDLE;
                    if (dev_reg && !rw_reg) begin
                        rdata_reg <= dev_rdata;
                    end
                end
                default: begin
                    R         <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Keyboard status/data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr15_reg <= 1'b0;
            kbsr14_reg <= 1'b0;
            kbdr_reg   <= 8'h00;
        end else begin
            if (kb_accept) begin
                kbdr_reg   <= kb_data;
                kbsr15_reg <= 1'b1;
            end else if (kbdr_rd) begin
                kbsr15_reg <= 1'b0;
            end
            if (kbsr_wr) begin
                kbsr14_reg <= mem_wdata[14];
            end
        end
    end

    // Display offer: one character buffered until the display takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
        end else begin
            if (ddr_wr && !dsp_valid) begin
                dsp_valid <= 1'b1;
                dsp_data  <= mem_wdata[7:0];
            end else if (dsp_valid && dsp_ready) begin
                dsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: each access pushes its expected
// result; a negedge monitor pops it when R pulses and checks data,
// latency and RAM-port activity.
module tb_lc3_mem_ctrl;

    localparam int WS = 2;

    logic        clk;
    logic        rst_n;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MAR;
    logic [15:0] MDR_in;
    logic [15:0] rdata;
    logic        R;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        INT;

    lc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MIO_EN    (MIO_EN),
        .R_W       (R_W),
        .MAR       (MAR),
        .MDR_in    (MDR_in),
        .rdata     (rdata),
        .R         (R),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready),
        .INT       (INT)
    );

    typedef struct {
        logic        rw;
        logic        dev;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          start;
        int          lat;
    } txn_t;

    txn_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          we_cnt = 0;
    logic        prev_r = 1'b0;
    logic [15:0] ram [0:15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Small RAM model indexed by the top address nibble.
    assign mem_rdata = mem_en ? ram[mem_addr[15:12]] : 16'hDEAD;

    initial forever begin
        @(posedge clk);
        if (mem_en && mem_we) ram[mem_addr[15:12]] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_dev(input logic [15:0] a);
        return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
    endfunction

    task automatic push_txn(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp);
        txn_t t;
        t.rw    = rw;
        t.dev   = is_dev(addr);
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = exp;
        t.start = cyc;
        t.lat   = t.dev ? 1 : WS + 1;
        sb_q.push_back(t);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp, input logic keep);
        logic got;
        got    = 1'b0;
        MIO_EN = 1'b1;
        R_W    = rw;
        MAR    = addr;
        MDR_in = wdata;
        push_txn(rw, addr, wdata, exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (R) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("R_timeout", {31'd0, got}, 32'd1);
            void'(sb_q.pop_back());
        end
        @(posedge clk);
        #1;
        if (!keep) MIO_EN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kb_char(input logic [7:0] d);
        kb_valid = 1'b1;
        kb_data  = d;
        @(posedge clk);
        #1;
        kb_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_R"},         {31'd0, R},         32'd0);
        check({phase, "_mem_en"},    {31'd0, mem_en},    32'd0);
        check({phase, "_mem_we"},    {31'd0, mem_we},    32'd0);
        check({phase, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        check({phase, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        check({phase, "_rdata"},     {16'd0, rdata},     32'd0);
        check({phase, "_dsp_valid"}, {31'd0, dsp_valid}, 32'd0);
        check({phase, "_dsp_data"},  {24'd0, dsp_data},  32'd0);
        check({phase, "_INT"},       {31'd0, INT},       32'd0);
    endtask

    // Monitor: RAM-port activity per access and scoreboard pop on R.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mem_en) begin
                en_cnt++;
                if (sb_q.size() == 0) begin
                    check("mem_en_unexpected", {31'd0, mem_en}, 32'd0);
                end else begin
                    check("mem_addr", {16'd0, mem_addr}, {16'd0, sb_q[0].addr});
                    if (mem_we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, sb_q[0].wdata});
                end
            end
            if (mem_we) we_cnt++;
            if (R) begin
                check("R_width", {31'd0, prev_r}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("R_unexpected", {31'd0, R}, 32'd0);
                end else begin
                    txn_t t;
                    t = sb_q.pop_front();
                    check("latency", cyc - t.start, t.lat);
                    if (!t.rw) check("rdata", {16'd0, rdata}, {16'd0, t.rdata});
                    check("mem_en_cycles", en_cnt, t.dev ? 0 : WS);
                    check("mem_we_cycles", we_cnt, (t.rw && !t.dev) ? WS : 0);
                    $display("txn %s addr=%04h wdata=%04h rdata=%04h exp=%04h lat=%0d",
                             t.rw ? "WR" : "RD", t.addr, t.wdata, rdata, t.rdata, cyc - t.start);
                end
                en_cnt = 0;
                we_cnt = 0;
            end
            prev_r = R;
        end else begin
            prev_r = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
        ram[3]    = 16'h1234;
        rst_n     = 1'b0;
        MIO_EN    = 1'b0;
        R_W       = 1'b0;
        MAR       = 16'h0000;
        MDR_in    = 16'h0000;
        kb_valid  = 1'b0;
        kb_data   = 8'h00;
        dsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // RAM read, write, read-back
        access(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0);
        access(1'b1, 16'h4000, 16'hBEEF, 16'h0000, 1'b0);
        check("mem_en_after_write", {31'd0, mem_en}, 32'd0);
        access(1'b0, 16'h4000, 16'h0000, 16'hBEEF, 1'b0);

        // Back-to-back: MIO_EN held high after DONE starts a fresh access
        access(1'b1, 16'h5000, 16'h1111, 16'h0000, 1'b1);
        access(1'b0, 16'h5000, 16'h0000, 16'h1111, 1'b0);
        idle(1);

        // Keyboard: character, enable interrupt, read clears
        kb_char(8'h41);
        check("INT_ie_off", {31'd0, INT}, 32'd0);
        access(1'b1, 16'hFE00, 16'h4000, 16'h0000, 1'b0);
        check("INT_set", {31'd0, INT}, 32'd1);
        access(1'b0, 16'hFE00, 16'h0000, 16'hC000, 1'b0);
        access(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b0);
        check("INT_clear", {31'd0, INT}, 32'd0);
        access(1'b0, 16'hFE00, 16'h0000, 16'h4000, 1'b0);

        // Overrun: second character dropped while KBSR15 set
        kb_char(8'h41);
        kb_char(8'h42);
        access(1'b0, 16'hFE02, 16'h0000, 16'h0041, 1'b0);
        check("INT_after_drop_read", {31'd0, INT}, 32'd0);

        // Character arriving in the KBDR-read DONE cycle: set wins
        kb_char(8'h43);
        MIO_EN = 1'b1;
        R_W    = 1'b0;
        MAR    = 16'hFE02;
        push_txn(1'b0, 16'hFE02, 16'h0000, 16'h0043);
        @(posedge clk);
        #1;
        kb_valid = 1'b1;
        kb_data  = 8'h44;
        @(posedge clk);
        #1;
        kb_valid = 1'b0;
        MIO_EN   = 1'b0;
        check("INT_set_wins", {31'd0, INT}, 32'd1);
        access(1'b0, 16'hFE02, 16'h0000, 16'h0044, 1'b0);
        check("INT_after_new_read", {31'd0, INT}, 32'd0);

        // Display: offer, DSR busy, drop second write, drain
        access(1'b1, 16'hFE06, 16'h0048, 16'h0000, 1'b0);
        check("dsp_valid_set", {31'd0, dsp_valid}, 32'd1);
        check("dsp_data", {24'd0, dsp_data}, 32'h48);
        access(1'b0, 16'hFE04, 16'h0000, 16'h0000, 1'b0);
        access(1'b1, 16'hFE06, 16'h0055, 16'h0000, 1'b0);
        check("dsp_data_kept", {24'd0, dsp_data}, 32'h48);
        dsp_ready = 1'b1;
        idle(1);
        dsp_ready = 1'b0;
        check("dsp_valid_clear", {31'd0, dsp_valid}, 32'd0);
        access(1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0);
        access(1'b0, 16'hFE06, 16'h0000, 16'h0000, 1'b0);

        // Build up state, then reset in the middle of a RAM access
        access(1'b1, 16'hFE06, 16'h0021, 16'h0000, 1'b0);
        kb_char(8'h55);
        check("pre_reset_INT", {31'd0, INT}, 32'd1);
        check("pre_reset_dsp_valid", {31'd0, dsp_valid}, 32'd1);
        MIO_EN = 1'b1;
        R_W    = 1'b0;
        MAR    = 16'h3000;
        push_txn(1'b0, 16'h3000, 16'h0000, 16'h1234);
        @(posedge clk);
        #1;
        check("busy_mem_en", {31'd0, mem_en}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        en_cnt = 0;
        we_cnt = 0;
        MIO_EN = 1'b0;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        access(1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0);
        idle(2);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
